hazard_match_pipe: RTL and testbench

HAZARD_MATCH_PIPE -- requirements
Module: hazard_match_pipe

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/haz_stage_reg.sv | 19 +
 rtl/hazard_match_pipe.sv | 80 ++++++++
 tb/tb_hazard_match_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard comparator pipeline: address width,
// match-vector bit positions and the per-stage entry layouts.
package hazard_pkg;

  localparam int REG_AW    = 4;

  localparam int MATCH_A_M = 4;
  localparam int MATCH_A_W = 3;
  localparam int MATCH_B_M = 2;
  localparam int MATCH_B_W = 1;
  localparam int MATCH_LDR = 0;

  typedef struct packed {
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] wa3;
    logic              reg_write;
    logic              mem_to_reg;
  } stage_entry_t;

  // Past Execute only the destination and its write enable have consumers.
  typedef struct packed {
    logic [REG_AW-1:0] wa3;
    logic              reg_write;
  } wb_entry_t;

endpackage

// File: rtl/haz_stage_reg.sv
// One pipeline-stage entry register: async active-low clear, synchronous
// flush that loads an all-zero bubble.
module haz_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (flush) q <= '0;
    else            q <= d;
  end

endmodule

// File: rtl/hazard_match_pipe.sv
// E/M/W register-address pipeline feeding the hazard unit's comparators.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_match_pipe
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1_d,
  input  logic [REG_AW-1:0] ra2_d,
  input  logic [REG_AW-1:0] wa3_d,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              flush_e,
  output logic [4:0]        match,
  output logic              reg_write_m,
  output logic              reg_write_w,
  output logic              mem_reg_e,
  output logic [REG_AW-1:0] wa3_e,
  output logic [REG_AW-1:0] wa3_m,
  output logic [REG_AW-1:0] wa3_w,
  output logic [15:0]       perf_flush_cnt,
  output logic [15:0]       perf_ldr_cnt
);

  stage_entry_t d_entry, e_q;
  wb_entry_t    m_d, m_q, w_q;

  assign d_entry = '{ra1: ra1_d, ra2: ra2_d, wa3: wa3_d,
                     reg_write: reg_write_d, mem_to_reg: mem_to_reg_d};
  assign m_d     = '{wa3: e_q.wa3, reg_write: e_q.reg_write};

  haz_stage_reg #(.W($bits(stage_entry_t))) u_stage_e (
    .clk(clk), .rst_n(rst_n), .flush(flush_e), .d(d_entry), .q(e_q)
  );

  haz_stage_reg #(.W($bits(wb_entry_t))) u_stage_m (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .d(m_d), .q(m_q)
  );

  haz_stage_reg #(.W($bits(wb_entry_t))) u_stage_w (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .d(m_q), .q(w_q)
  );

  // Raw address compares; write-enable qualification is the hazard unit's job.
  always_comb begin
    match            = '0;
    match[MATCH_A_M] = (e_q.ra1 == m_q.wa3);
    match[MATCH_A_W] = (e_q.ra1 == w_q.wa3);
    match[MATCH_B_M] = (e_q.ra2 == m_q.wa3);
    match[MATCH_B_W] = (e_q.ra2 == w_q.wa3);
    match[MATCH_LDR] = (ra1_d == e_q.wa3) | (ra2_d == e_q.wa3);
  end

  assign mem_reg_e   = e_q.mem_to_reg;
  assign reg_write_m = m_q.reg_write;
  assign reg_write_w = w_q.reg_write;
  assign wa3_e       = e_q.wa3;
  assign wa3_m       = m_q.wa3;
  assign wa3_w       = w_q.wa3;

`ifdef HAZARD_PERF_CNT_EN
  logic ldr_evt;
  assign ldr_evt = match[MATCH_LDR] & mem_reg_e;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_cnt <= '0;
      perf_ldr_cnt   <= '0;
    end else begin
      if (flush_e && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
      if (ldr_evt && perf_ldr_cnt != 16'hFFFF)   perf_ldr_cnt   <= perf_ldr_cnt + 16'd1;
    end
  end
`else
  assign perf_flush_cnt = '0;
  assign perf_ldr_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Bench for hazard_match_pipe: random and directed stimulus checked every
// cycle against a three-deep instruction-history model.
module tb_hazard_match_pipe;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ra1_d = '0, ra2_d = '0, wa3_d = '0;
  logic       reg_write_d = 1'b0, mem_to_reg_d = 1'b0, flush_e = 1'b0;
  logic [4:0] match;
  logic       reg_write_m, reg_write_w, mem_reg_e;
  logic [3:0] wa3_e, wa3_m, wa3_w;
  logic [15:0] perf_flush_cnt, perf_ldr_cnt;

  hazard_match_pipe dut (
    .clk(clk), .rst_n(rst_n), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .flush_e(flush_e),
    .match(match), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_reg_e(mem_reg_e), .wa3_e(wa3_e), .wa3_m(wa3_m), .wa3_w(wa3_w),
    .perf_flush_cnt(perf_flush_cnt), .perf_ldr_cnt(perf_ldr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: exp_q[0]=instruction now in E, [1]=in M, [2]=in W.
  // Entry packing {ra1[13:10], ra2[9:6], wa3[5:2], reg_write[1], mem_to_reg[0]}.
  logic [13:0] exp_q[$];
  int model_flush_cnt = 0;
  int model_ldr_cnt   = 0;

  function automatic logic [4:0] model_match(input logic [3:0] a1_d, input logic [3:0] a2_d);
    logic [13:0] e, m, w;
    e = exp_q[0]; m = exp_q[1]; w = exp_q[2];
    model_match[4] = (e[13:10] == m[5:2]);
    model_match[3] = (e[13:10] == w[5:2]);
    model_match[2] = (e[9:6]   == m[5:2]);
    model_match[1] = (e[9:6]   == w[5:2]);
    model_match[0] = (a1_d == e[5:2]) || (a2_d == e[5:2]);
  endfunction

  task automatic model_clear();
    exp_q = {14'd0, 14'd0, 14'd0};
    model_flush_cnt = 0;
    model_ldr_cnt   = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      logic [4:0] mm;
      mm = model_match(ra1_d, ra2_d);
      if (flush_e) model_flush_cnt = (model_flush_cnt < 65535) ? model_flush_cnt + 1 : 65535;
      if (mm[0] && exp_q[0][0]) model_ldr_cnt = (model_ldr_cnt < 65535) ? model_ldr_cnt + 1 : 65535;
      exp_q.push_front(flush_e ? 14'd0 : {ra1_d, ra2_d, wa3_d, reg_write_d, mem_to_reg_d});
      void'(exp_q.pop_back());
    end
  end

  // Scoreboard compare, every cycle on the falling edge.
  always @(negedge clk) begin
    logic [13:0] e, m, w;
    e = exp_q[0]; m = exp_q[1]; w = exp_q[2];
    chk("match",          {27'd0, match},       {27'd0, model_match(ra1_d, ra2_d)});
    chk("mem_reg_e",      {31'd0, mem_reg_e},   {31'd0, e[0]});
    chk("reg_write_m",    {31'd0, reg_write_m}, {31'd0, m[1]});
    chk("reg_write_w",    {31'd0, reg_write_w}, {31'd0, w[1]});
    chk("wa3_e",          {28'd0, wa3_e},       {28'd0, e[5:2]});
    chk("wa3_m",          {28'd0, wa3_m},       {28'd0, m[5:2]});
    chk("wa3_w",          {28'd0, wa3_w},       {28'd0, w[5:2]});
    chk("perf_flush_cnt", {16'd0, perf_flush_cnt}, PERF ? model_flush_cnt : 32'd0);
    chk("perf_ldr_cnt",   {16'd0, perf_ldr_cnt},   PERF ? model_ldr_cnt   : 32'd0);
  end

  // driver tasks
  task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wd,
                       input logic rw, input logic mr, input logic fl);
    ra1_d = a1; ra2_d = a2; wa3_d = wd;
    reg_write_d = rw; mem_to_reg_d = mr; flush_e = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    // Reset state: every address zero so all comparators hit.
    chk("rst_match",  {27'd0, match}, 32'h1F);
    chk("rst_rw_m",   {31'd0, reg_write_m}, 32'd0);
    chk("rst_wa3_w",  {28'd0, wa3_w}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Forwarding through M then W.
    drive(4'd9, 4'd9, 4'd3, 1'b1, 1'b0, 1'b0); step();
    drive(4'd3, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0); step();
    chk("fwd_match4", {31'd0, match[4]}, 32'd1);
    chk("fwd_rw_m",   {31'd0, reg_write_m}, 32'd1);
    step();
    chk("fwd_match3", {31'd0, match[3]}, 32'd1);
    chk("fwd_match4_off", {31'd0, match[4]}, 32'd0);
    chk("fwd_wa3_w",  {28'd0, wa3_w}, 32'd3);

    // Load-use against a load sitting in E.
    drive(4'd9, 4'd9, 4'd5, 1'b1, 1'b1, 1'b0); step();
    drive(4'd9, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("ldr_mem_reg_e", {31'd0, mem_reg_e}, 32'd1);
    chk("ldr_match0",    {31'd0, match[0]}, 32'd1);
    step();
    chk("ldr_cnt", {16'd0, perf_ldr_cnt}, PERF ? 32'd1 : 32'd0);

    // Flush beats valid decode data, bubble reaches W.
    drive(4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1); step();
    chk("flush_wa3_e", {28'd0, wa3_e}, 32'd0);
    chk("flush_mem_reg_e", {31'd0, mem_reg_e}, 32'd0);
    drive(4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0); step(); step();
    chk("flush_rw_w",  {31'd0, reg_write_w}, 32'd0);
    chk("flush_wa3_w", {28'd0, wa3_w}, 32'd0);

    // Async reset with writes in flight in M and W.
    drive(4'd9, 4'd9, 4'd2, 1'b1, 1'b0, 1'b0); step(); step(); step();
    chk("pre_rst_rw_m", {31'd0, reg_write_m}, 32'd1);
    chk("pre_rst_rw_w", {31'd0, reg_write_w}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rw_m",  {31'd0, reg_write_m}, 32'd0);
    chk("async_rw_w",  {31'd0, reg_write_w}, 32'd0);
    chk("async_wa3_e", {28'd0, wa3_e}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic, narrow address range so comparators fire often.
    for (int i = 0; i < 2000; i++) begin
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      step();
    end

    // Counter saturation under a long flush.
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (70000) step();
    chk("sat_flush_cnt", {16'd0, perf_flush_cnt}, PERF ? 32'hFFFF : 32'd0);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
